// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 encodings,
// FSM state encoding and an access-size decode helper.
package mem_access_unit_pkg;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    typedef enum logic [1:0] {
        MAU_IDLE = 2'b00,
        MAU_BUSY = 2'b01,
        MAU_DONE = 2'b10
    } mau_state_e;

    typedef enum logic [1:0] {
        LS_SZ_BYTE = 2'b00,
        LS_SZ_HALF = 2'b01,
        LS_SZ_WORD = 2'b10
    } ls_size_e;

    // Undefined funct3 codes fall through to word size.
    function automatic ls_size_e ls_size(input logic [2:0] funct3);
        ls_size_e sz;
        case (funct3)
            LS_B, LS_BU: sz = LS_SZ_BYTE;
            LS_H, LS_HU: sz = LS_SZ_HALF;
            default:     sz = LS_SZ_WORD;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Combinational lane select and sign/zero extension of a memory read word.
module load_extend (
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    import mem_access_unit_pkg::*;

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed byte and halfword lanes.
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        case (addr_lo)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            2'b11:   byte_s = rdata[31:24];
            default: byte_s = rdata[7:0];
        endcase
        if (addr_lo[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
    end

    // Extend the selected lane according to the load type.
    always_comb begin
        data = rdata;
        case (funct3)
            LS_B:    data = {{24{byte_s[7]}}, byte_s};
            LS_H:    data = {{16{half_s[15]}}, half_s};
            LS_BU:   data = {24'h000000, byte_s};
            LS_HU:   data = {16'h0000, half_s};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: data-memory request/ready handshake, pipeline stall, load extension.
// Build option MISALIGN_TRAP_EN: misaligned H/W accesses are dropped and flagged on misalign_err.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read_MEM,
    input  logic        mem_write_MEM,
    input  logic [2:0]  funct3_MEM,
    input  logic [31:0] addr_MEM,
    input  logic [31:0] store_data_MEM,
    input  logic [4:0]  reg_dest_MEM,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    output logic [31:0] load_data_MEM,
    output logic        stall_mem,
    output logic [4:0]  busy_dest
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        misalign_err
`endif
);
    import mem_access_unit_pkg::*;

    mau_state_e  state_r;
    mau_state_e  state_nxt_s;
    logic        access_s;
    logic        misalign_s;
    logic        req_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;
    logic [31:0] ext_s;
    logic [2:0]  funct3_r;
    logic [1:0]  addr_lo_r;

    assign access_s = mem_read_MEM | mem_write_MEM;

`ifdef MISALIGN_TRAP_EN
    // Halfwords need addr[0]=0, words need addr[1:0]=0.
    always_comb begin
        misalign_s = 1'b0;
        case (ls_size(funct3_MEM))
            LS_SZ_HALF: misalign_s = addr_MEM[0];
            LS_SZ_WORD: misalign_s = (addr_MEM[1:0] != 2'b00);
            default:    misalign_s = 1'b0;
        endcase
    end
`else
    assign misalign_s = 1'b0;
`endif

    assign req_s = access_s & ~misalign_s;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= MAU_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state and stall; DONE releases the pipeline for exactly one cycle.
    always_comb begin
        state_nxt_s = state_r;
        stall_mem   = 1'b0;
        case (state_r)
            MAU_IDLE: begin
                stall_mem = req_s;
                if (req_s) begin
                    state_nxt_s = MAU_BUSY;
                end else begin
                    state_nxt_s = MAU_IDLE;
                end
            end
            MAU_BUSY: begin
                stall_mem = 1'b1;
                if (dmem_ready) begin
                    state_nxt_s = MAU_DONE;
                end else begin
                    state_nxt_s = MAU_BUSY;
                end
            end
            MAU_DONE: state_nxt_s = MAU_IDLE;
            default:  state_nxt_s = MAU_IDLE;
        endcase
    end

    // Byte enables and lane-replicated store data; stores win if both strobes are set.
    always_comb begin
        be_s    = 4'b1111;
        wdata_s = store_data_MEM;
        if (mem_write_MEM) begin
            case (ls_size(funct3_MEM))
                LS_SZ_BYTE: begin
                    be_s    = 4'b0001 << addr_MEM[1:0];
                    wdata_s = {4{store_data_MEM[7:0]}};
                end
                LS_SZ_HALF: begin
                    be_s    = 4'b0011 << {addr_MEM[1], 1'b0};
                    wdata_s = {2{store_data_MEM[15:0]}};
                end
                default: begin
                    be_s    = 4'b1111;
                    wdata_s = store_data_MEM;
                end
            endcase
        end else begin
            be_s    = 4'b1111;
            wdata_s = store_data_MEM;
        end
    end

    load_extend u_load_extend (
        .rdata   (dmem_rdata),
        .addr_lo (addr_lo_r),
        .funct3  (funct3_r),
        .data    (ext_s)
    );

    // Request outputs latch on issue and stay frozen until memory completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= 32'h0000_0000;
            dmem_wdata    <= 32'h0000_0000;
            dmem_be       <= 4'b0000;
            busy_dest     <= 5'd0;
            funct3_r      <= 3'b000;
            addr_lo_r     <= 2'b00;
            load_data_MEM <= 32'h0000_0000;
        end else begin
            case (state_r)
                MAU_IDLE: begin
                    if (req_s) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= mem_write_MEM;
                        dmem_addr  <= {addr_MEM[31:2], 2'b00};
                        dmem_wdata <= wdata_s;
                        dmem_be    <= be_s;
                        busy_dest  <= mem_write_MEM ? 5'd0 : reg_dest_MEM;
                        funct3_r   <= funct3_MEM;
                        addr_lo_r  <= addr_MEM[1:0];
                    end
                end
                MAU_BUSY: begin
                    if (dmem_ready) begin
                        dmem_req  <= 1'b0;
                        busy_dest <= 5'd0;
                        if (!dmem_we) begin
                            load_data_MEM <= ext_s;
                        end
                    end
                end
                MAU_DONE: begin
                    dmem_req  <= 1'b0;
                    busy_dest <= 5'd0;
                end
                default: begin
                    dmem_req  <= 1'b0;
                    busy_dest <= 5'd0;
                end
            endcase
        end
    end

`ifdef MISALIGN_TRAP_EN
    // One-cycle flag per misaligned instruction seen in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= (state_r == MAU_IDLE) & access_s & misalign_s;
        end
    end
`endif

endmodule
